// File: rtl/curve448_pkg.sv
// curve448_pkg: shared field width, fault-guard state encoding and counter sizing
package curve448_pkg;
  localparam int FIELD_W = 448;
  typedef enum logic [1:0] {IDLE, OUT, RETRY, LOCK} fault_state_t;
  typedef logic [FIELD_W-1:0] fe_t;
  function automatic int cnt_w(input int max_retry);
    return max_retry > 0 ? $clog2(max_retry + 1) : 1;
  endfunction
endpackage

// File: rtl/ladder_fault_guard_if.sv
// ladder_fault_guard_if: ladder result in, verified result out, retry and alarm sideband
interface ladder_fault_guard_if
  import curve448_pkg::*;
#(
  parameter int WIDTH = FIELD_W,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W = cnt_w(MAX_RETRY)
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic in_error;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  logic retry_req;
  logic [CNT_W-1:0] retry_cnt;
  logic fault_alarm;
  logic clear_alarm;
  modport master (
    output in_valid, in_data, in_error, out_ready, clear_alarm,
    input in_ready, out_valid, out_data, retry_req, retry_cnt, fault_alarm
  );
  modport slave (
    input in_valid, in_data, in_error, out_ready, clear_alarm,
    output in_ready, out_valid, out_data, retry_req, retry_cnt, fault_alarm
  );
endinterface

// File: rtl/ladder_fault_guard.sv
// ladder_fault_guard: forwards clean ladder results, requests recomputes on mismatch, locks when retries run out
module ladder_fault_guard
  import curve448_pkg::*;
#(
  parameter int WIDTH = FIELD_W,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W = cnt_w(MAX_RETRY)
) (
  input logic clk,
  input logic rst_n,
  ladder_fault_guard_if.slave bus
);
  fault_state_t state, state_d;
  logic [WIDTH-1:0] data, data_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic can_retry;
  assign can_retry = cnt != CNT_W'(MAX_RETRY);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      data <= '0;
      cnt <= '0;
    end else begin
      state <= state_d;
      data <= data_d;
      cnt <= cnt_d;
    end
  end
  always_comb begin
    state_d = state;
    data_d = data;
    cnt_d = cnt;
    unique case (state)
      IDLE: if (bus.in_valid) begin
        state_d = !bus.in_error ? OUT : can_retry ? RETRY : LOCK;
        data_d = bus.in_error ? '0 : bus.in_data;
        cnt_d = bus.in_error && can_retry ? cnt + CNT_W'(1) : cnt;
      end
      OUT: if (bus.out_ready) begin
        state_d = IDLE;
        data_d = '0;
        cnt_d = '0;
      end
      RETRY: state_d = IDLE;
      LOCK: begin
        data_d = '0;
        state_d = bus.clear_alarm ? IDLE : LOCK;
        cnt_d = bus.clear_alarm ? '0 : cnt;
      end
      default: state_d = IDLE;
    endcase
  end
  // Every output decodes from registered state, so nothing on in_* reaches out_* combinationally
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == OUT;
  assign bus.out_data = state == OUT ? data : '0;
  assign bus.retry_req = state == RETRY;
  assign bus.retry_cnt = cnt;
  assign bus.fault_alarm = state == LOCK;
endmodule

// File: tb/tb_ladder_fault_guard.sv
// tb_ladder_fault_guard: table-driven check of the MAX_RETRY=2 guard plus a MAX_RETRY=0 sequence
module tb_ladder_fault_guard;
  import curve448_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  ladder_fault_guard_if #(.WIDTH(FIELD_W), .MAX_RETRY(2)) b2 ();
  ladder_fault_guard_if #(.WIDTH(FIELD_W), .MAX_RETRY(0)) b0 ();
  ladder_fault_guard #(.WIDTH(FIELD_W), .MAX_RETRY(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  ladder_fault_guard #(.WIDTH(FIELD_W), .MAX_RETRY(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  typedef struct {
    logic rst_n, v;
    logic [15:0] d;
    logic e, ordy, clr;
    logic ir, ov;
    logic [15:0] od;
    logic rr;
    logic [1:0] rc;
    logic fa;
  } vec_t;
  vec_t vq[$];
  function automatic vec_t mk(logic r, logic v, logic [15:0] d, logic e, logic ordy, logic clr,
                              logic ir, logic ov, logic [15:0] od, logic rr, logic [1:0] rc, logic fa);
    vec_t t;
    t.rst_n = r; t.v = v; t.d = d; t.e = e; t.ordy = ordy; t.clr = clr;
    t.ir = ir; t.ov = ov; t.od = od; t.rr = rr; t.rc = rc; t.fa = fa;
    return t;
  endfunction
  task automatic chk(input string name, input fe_t act, input fe_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    b2.in_valid = 0; b2.in_data = '0; b2.in_error = 0; b2.out_ready = 0; b2.clear_alarm = 0;
    b0.in_valid = 0; b0.in_data = '0; b0.in_error = 0; b0.out_ready = 0; b0.clear_alarm = 0;
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 16'h0005, 0, 1, 0, 0, 1, 16'h0005, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 16'h003c, 0, 0, 0, 0, 1, 16'h003c, 0, 0, 0));
    for (int i = 0; i < 5; i++) vq.push_back(mk(1, 1, 16'h0077, 1, 0, 0, 0, 1, 16'h003c, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 16'h0011, 1, 0, 0, 0, 0, 0, 1, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    vq.push_back(mk(1, 1, 16'h0022, 0, 0, 0, 0, 1, 16'h0022, 0, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 16'h0033, 1, 0, 0, 0, 0, 0, 1, 1, 0));
    vq.push_back(mk(1, 1, 16'h0099, 0, 1, 0, 1, 0, 0, 0, 1, 0));
    vq.push_back(mk(1, 1, 16'h0033, 1, 0, 0, 0, 0, 0, 1, 2, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0));
    vq.push_back(mk(1, 1, 16'h0033, 1, 0, 0, 0, 0, 0, 0, 2, 1));
    vq.push_back(mk(1, 1, 16'h0044, 0, 1, 0, 0, 0, 0, 0, 2, 1));
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 16'h0066, 0, 1, 0, 0, 1, 16'h0066, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 16'h0055, 0, 0, 0, 0, 1, 16'h0055, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 16'h0001, 1, 0, 0, 0, 0, 0, 1, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    vq.push_back(mk(1, 1, 16'h0001, 1, 0, 0, 0, 0, 0, 1, 2, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0));
    vq.push_back(mk(1, 1, 16'h0001, 1, 0, 0, 0, 0, 0, 0, 2, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    foreach (vq[i]) begin
      @(negedge clk);
      rst_n = vq[i].rst_n;
      b2.in_valid = vq[i].v;
      b2.in_data = fe_t'(vq[i].d);
      b2.in_error = vq[i].e;
      b2.out_ready = vq[i].ordy;
      b2.clear_alarm = vq[i].clr;
      tick();
      chk($sformatf("row%0d in_ready", i), fe_t'(b2.in_ready), fe_t'(vq[i].ir));
      chk($sformatf("row%0d out_valid", i), fe_t'(b2.out_valid), fe_t'(vq[i].ov));
      chk($sformatf("row%0d out_data", i), b2.out_data, fe_t'(vq[i].od));
      chk($sformatf("row%0d retry_req", i), fe_t'(b2.retry_req), fe_t'(vq[i].rr));
      chk($sformatf("row%0d retry_cnt", i), fe_t'(b2.retry_cnt), fe_t'(vq[i].rc));
      chk($sformatf("row%0d fault_alarm", i), fe_t'(b2.fault_alarm), fe_t'(vq[i].fa));
    end
    @(negedge clk);
    b0.clear_alarm = 1;
    tick();
    chk("m0 clear_in_idle in_ready", fe_t'(b0.in_ready), fe_t'(1'b1));
    chk("m0 clear_in_idle fault_alarm", fe_t'(b0.fault_alarm), fe_t'(1'b0));
    @(negedge clk);
    b0.clear_alarm = 0; b0.in_valid = 1; b0.in_error = 1; b0.in_data = fe_t'(16'h0009);
    tick();
    chk("m0 lock fault_alarm", fe_t'(b0.fault_alarm), fe_t'(1'b1));
    chk("m0 lock retry_req", fe_t'(b0.retry_req), fe_t'(1'b0));
    chk("m0 lock in_ready", fe_t'(b0.in_ready), fe_t'(1'b0));
    chk("m0 lock out_data", b0.out_data, '0);
    chk("m0 lock retry_cnt", fe_t'(b0.retry_cnt), '0);
    @(negedge clk);
    b0.in_valid = 0;
    tick();
    chk("m0 hold fault_alarm", fe_t'(b0.fault_alarm), fe_t'(1'b1));
    chk("m0 hold retry_req", fe_t'(b0.retry_req), fe_t'(1'b0));
    @(negedge clk);
    b0.clear_alarm = 1;
    tick();
    chk("m0 cleared fault_alarm", fe_t'(b0.fault_alarm), fe_t'(1'b0));
    chk("m0 cleared in_ready", fe_t'(b0.in_ready), fe_t'(1'b1));
    @(negedge clk);
    b0.clear_alarm = 0; b0.in_valid = 1; b0.in_error = 0; b0.in_data = fe_t'(16'h0007); b0.out_ready = 1;
    tick();
    chk("m0 clean out_valid", fe_t'(b0.out_valid), fe_t'(1'b1));
    chk("m0 clean out_data", b0.out_data, fe_t'(16'h0007));
    @(negedge clk);
    b0.in_valid = 0;
    tick();
    chk("m0 done out_valid", fe_t'(b0.out_valid), fe_t'(1'b0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
